remote_comm: RTL and testbench
==============================

# remote_comm

Host-side command transmitter and response receiver for the knight robot. It takes a 16-bit command word, serializes it over a UART link as two 8N1 bytes (high byte first), and flags completion. It also receives the robot's 8-bit response bytes (e.g. ack 0xA5) on the return line. It sits in the bench/host domain, wired TX→robot RX and RX←robot TX.

## Interface
- BAUD_DIV, default 2604: clocks per UART bit (50 MHz / 19200 baud); must be ≥ 4.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- cmd  in  16  command word; captured on snd_cmd
- snd_cmd  in  1  one-cycle request to send cmd
- cmd_snt  out  1  set when both bytes fully sent; held until next accepted snd_cmd
- TX  out  1  serial output to robot, idle high
- RX  in  1  serial input from robot, asynchronous, idle high
- resp  out  8  last received response byte
- resp_rdy  out  1  set when a response byte completes; cleared at next start bit or accepted snd_cmd

## Operation
- Reset values: TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00; TX FSM IDLE; RX FSM IDLE; RX synchronizer flops preset to 1.
- Command FSM states: IDLE, HIGH, LOW.
- IDLE→HIGH on snd_cmd: latch cmd, clear cmd_snt, clear resp_rdy, start byte cmd[15:8].
- HIGH→LOW when the stop bit of the high byte ends; LOW starts byte cmd[7:0] with no gap.
- LOW→IDLE when the low-byte stop bit ends; cmd_snt←1 the same cycle.
- snd_cmd while HIGH/LOW: ignored; the latched command is not altered.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV clocks.
- RX path:
  - RX double-flopped before use.
  - Falling edge in IDLE starts a frame; resp_rdy cleared.
  - Samples are taken at BAUD_DIV/2 into the start bit, then every BAUD_DIV clocks.
  - After the 8th data bit plus the stop-bit sample: resp←shift register, resp_rdy←1.
  - Stop-bit value is not checked.
- TX and RX are fully independent; a response may arrive while a command is transmitting.
- Payload is opaque. Reference encodings:
  - 16'h2000: calibrate gyro.
  - 16'h4HHN: move; HH=heading (00 north, 3F west, 7F south, BF east), N=squares.
  - 16'h5HHN: move with fanfare.
  - Response 8'hA5: positive ack.

## Timing
- snd_cmd sampled at edge k → TX start bit driven from edge k+1.
- High-byte frame: 10×BAUD_DIV clocks; low-byte frame follows immediately.
- cmd_snt rises at edge k+1+20×BAUD_DIV.
- RX latency: resp_rdy rises 2 (synchronizer) + BAUD_DIV/2 + 9×BAUD_DIV clocks after RX falls.
- rst mid-operation: next edge forces TX=1 and all FSMs to IDLE; partial frames are abandoned; outputs return to reset values.
- Baud counters are 12 bits (≥ log2(BAUD_DIV)+1); bit counters are 4 bits; no wrap beyond a frame.

## Structure
- Package knight_pkg: BAUD_DIV default, ACK=8'hA5, command opcode and heading constants.
- Sub-module uart: a tx half (trmt, tx_data, tx_done) and an rx half (rdy, rx_data, clr_rdy).
- remote_comm: the 3-state command FSM plus byte mux around uart.

## Test plan
Use BAUD_DIV=16 with a loopback model robot.
- Reset: hold rst 3 cycles → TX=1, cmd_snt=0, resp_rdy=0, resp=00.
- snd_cmd with cmd=16'h43F2 → bytes 8'h43 then 8'hF2 decoded at the model; cmd_snt rises exactly 1+320 clocks after snd_cmd.
- A second snd_cmd mid-frame with cmd=16'h5001 → still sends 43,F2; then an accepted 5001 sends 50,01 and cmd_snt drops for its duration.
- Model sends 8'hA5 → resp=A5 and resp_rdy=1 at 2+8+144 clocks after the start edge; a later 8'h5A falling edge clears resp_rdy until that byte completes.
- rst asserted mid-low-byte → TX=1 next cycle, cmd_snt=0; a fresh snd_cmd 16'h2000 then completes normally.
- Simultaneous TX of 16'h2000 and RX of A5 → both complete correctly and independently.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared constants for the knight robot host link: baud default, ack byte,
// command opcodes/headings and the command FSM state type.
package knight_pkg;
   localparam int BAUD_DIV_DEF = 2604;
   localparam int BAUD_W       = 12;
   localparam int BIT_W        = 4;

   localparam logic [7:0]  ACK        = 8'hA5;
   localparam logic [15:0] CMD_CAL    = 16'h2000;
   localparam logic [3:0]  OP_MOVE    = 4'h4;
   localparam logic [3:0]  OP_FANFARE = 4'h5;
   localparam logic [7:0]  HEAD_NORTH = 8'h00;
   localparam logic [7:0]  HEAD_WEST  = 8'h3F;
   localparam logic [7:0]  HEAD_SOUTH = 8'h7F;
   localparam logic [7:0]  HEAD_EAST  = 8'hBF;

   typedef enum logic [1:0] {
      CMD_IDLE,
      CMD_HIGH,
      CMD_LOW
   } cmd_state_e;

   function automatic logic [15:0] move_cmd(input logic fanfare, input logic [7:0] heading,
                                            input logic [3:0] squares);
      return {(fanfare ? OP_FANFARE : OP_MOVE), heading, squares};
   endfunction
endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART with independent transmit and receive halves. The transmitter can
// be reloaded in the very cycle its stop bit ends, giving back-to-back frames.
module uart
   import knight_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       TX,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic       rdy,
   output logic [7:0] rx_data
);
   localparam logic [BAUD_W-1:0] BAUD_LAST = 12'(BAUD_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = 12'(BAUD_DIV / 2 - 2);

   logic              tx_busy_q, tx_busy_d, tx_q, tx_d, tx_tick;
   logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
   logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
   logic [8:0]        tx_shift_q, tx_shift_d;

   logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   logic              rx_busy_q, rx_busy_d, rdy_q, rdy_d, rx_fall, rx_sample;
   logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
   logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;

   assign tx_tick = tx_busy_q && (tx_baud_q == BAUD_LAST);
   assign tx_done = tx_tick && (tx_bit_q == 4'd9);
   assign TX      = tx_q;

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_q_hold: begin end
      tx_d       = tx_q;
      tx_baud_d  = tx_busy_q ? tx_baud_q + 12'd1 : tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      if (tx_tick) begin
         tx_baud_d = '0;
         if (tx_done) begin
            tx_busy_d = 1'b0;
            tx_d      = 1'b1;
         end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
         end
      end
      // A load in the stop-bit's final cycle chains the next frame with no idle gap.
      if (trmt && (!tx_busy_q || tx_done)) begin
         tx_busy_d  = 1'b1;
         tx_d       = 1'b0;
         tx_baud_d  = '0;
         tx_bit_d   = '0;
         tx_shift_d = {1'b1, tx_data};
      end
   end

   assign rx_fall   = !rx_busy_q && rx_prev_q && !rx_s2_q;
   assign rx_sample = rx_busy_q &&
                      (rx_baud_q == ((rx_bit_q == 4'd0) ? BAUD_HALF : BAUD_LAST));
   assign rdy       = rdy_q;
   assign rx_data   = rx_data_q;

   always_comb begin
      rx_s1_d    = RX;
      rx_s2_d    = rx_s1_q;
      rx_prev_d  = rx_s2_q;
      rx_busy_d  = rx_busy_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rdy_d      = clr_rdy ? 1'b0 : rdy_q;
      if (rx_fall) begin
         rx_busy_d = 1'b1;
         rx_baud_d = '0;
         rx_bit_d  = '0;
         rdy_d     = 1'b0;
      end else if (rx_busy_q) begin
         rx_baud_d = rx_baud_q + 12'd1;
         if (rx_sample) begin
            rx_baud_d = '0;
            rx_bit_d  = rx_bit_q + 4'd1;
            if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9)
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 4'd9) begin
               rx_busy_d = 1'b0;
               rx_data_d = rx_shift_q;
               rdy_d     = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      if (rst) begin
         tx_busy_q <= 1'b0;
         tx_q      <= 1'b1;
         tx_baud_q <= '0;
         tx_bit_q  <= '0;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_busy_q <= 1'b0;
         rx_baud_q <= '0;
         rx_bit_q  <= '0;
         rx_data_q <= 8'h00;
         rdy_q     <= 1'b0;
      end else begin
         tx_busy_q <= tx_busy_d;
         tx_q      <= tx_d;
         tx_baud_q <= tx_baud_d;
         tx_bit_q  <= tx_bit_d;
         rx_s1_q   <= rx_s1_d;
         rx_s2_q   <= rx_s2_d;
         rx_prev_q <= rx_prev_d;
         rx_busy_q <= rx_busy_d;
         rx_baud_q <= rx_baud_d;
         rx_bit_q  <= rx_bit_d;
         rx_data_q <= rx_data_d;
         rdy_q     <= rdy_d;
      end
   end
endmodule

// File: rtl/remote_comm.sv
// Host-side command sender: serializes a 16-bit command as two UART bytes
// (high first) and reports the robot's response bytes.
module remote_comm
   import knight_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd,
   input  logic        snd_cmd,
   output logic        cmd_snt,
   output logic        TX,
   input  logic        RX,
   output logic [7:0]  resp,
   output logic        resp_rdy
);
   cmd_state_e  state_q, state_d;
   logic [15:0] cmd_q, cmd_d;
   logic        start_q, start_d, cmd_snt_q, cmd_snt_d;
   logic        accept, trmt, tx_done;
   logic [7:0]  tx_data;

   assign accept  = (state_q == CMD_IDLE) && snd_cmd;
   // First byte launches from the registered start pulse; the second chains off tx_done.
   assign trmt    = start_q || ((state_q == CMD_HIGH) && tx_done);
   assign tx_data = start_q ? cmd_q[15:8] : cmd_q[7:0];
   assign cmd_snt = cmd_snt_q;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      start_d   = 1'b0;
      cmd_snt_d = cmd_snt_q;
      case (state_q)
         CMD_IDLE: if (snd_cmd) begin
            state_d   = CMD_HIGH;
            cmd_d     = cmd;
            start_d   = 1'b1;
            cmd_snt_d = 1'b0;
         end
         CMD_HIGH: if (tx_done) state_d = CMD_LOW;
         CMD_LOW: if (tx_done) begin
            state_d   = CMD_IDLE;
            cmd_snt_d = 1'b1;
         end
         default: state_d = CMD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      cmd_q <= cmd_d;
      if (rst) begin
         state_q   <= CMD_IDLE;
         start_q   <= 1'b0;
         cmd_snt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         cmd_snt_q <= cmd_snt_d;
      end
   end

   uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk     (clk),
      .rst     (rst),
      .trmt    (trmt),
      .tx_data (tx_data),
      .tx_done (tx_done),
      .TX      (TX),
      .RX      (RX),
      .clr_rdy (accept),
      .rdy     (resp_rdy),
      .rx_data (resp)
   );
endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm with a model robot decoding TX and driving RX.
module tb_remote_comm;
   localparam int BD = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cmd = 16'h0000;
   logic        snd_cmd = 1'b0;
   logic        cmd_snt, tx_line, resp_rdy;
   logic        rx_line = 1'b1;
   logic [7:0]  resp;

   int tests = 0;
   int fails = 0;
   int rst_cnt = 0;
   bit mon_en = 1'b0;
   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];

   typedef struct packed { logic [15:0] c; logic [7:0] hi; logic [7:0] lo; } tx_vec_t;
   typedef struct packed { logic [7:0] b; logic [7:0] exp_resp; } rx_vec_t;
   tx_vec_t tx_tab[4];
   rx_vec_t rx_tab[4];

   remote_comm #(.BAUD_DIV(BD)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd),
      .snd_cmd  (snd_cmd),
      .cmd_snt  (cmd_snt),
      .TX       (tx_line),
      .RX       (rx_line),
      .resp     (resp),
      .resp_rdy (resp_rdy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model robot receiver: decode TX frames, compare against the scoreboard.
   initial begin
      logic [7:0] b;
      logic       stop;
      int         r0;
      forever begin
         @(negedge clk);
         if (mon_en && tx_line === 1'b0) begin
            r0 = rst_cnt;
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = tx_line;
            end
            repeat (BD) @(negedge clk);
            stop = tx_line;
            if (rst_cnt == r0) begin
               check("tx_stop", 32'(stop), 32'd1);
               if (tx_exp_q.size() == 0) check("tx_unexpected_byte", 32'(b), 32'hFFFF_FFFF);
               else check("tx_byte", 32'(b), 32'(tx_exp_q.pop_front()));
            end
         end
      end
   end

   // Response scoreboard: pop on each rising resp_rdy.
   initial begin
      logic prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (resp_rdy === 1'b1 && prev !== 1'b1) begin
            if (rx_exp_q.size() == 0) check("rx_unexpected", 32'(resp), 32'hFFFF_FFFF);
            else check("resp_byte", 32'(resp), 32'(rx_exp_q.pop_front()));
         end
         prev = resp_rdy;
      end
   end

   task automatic robot_send(input logic [7:0] b);
      rx_line = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (BD) @(negedge clk);
      end
      rx_line = 1'b1;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_timed(input logic [15:0] c, input logic [7:0] hi, input logic [7:0] lo);
      int n;
      bit got;
      tx_exp_q.push_back(hi);
      tx_exp_q.push_back(lo);
      @(negedge clk);
      cmd = c;
      snd_cmd = 1'b1;
      @(posedge clk);
      #1;
      snd_cmd = 1'b0;
      check("cmd_snt_clear", 32'(cmd_snt), 32'd0);
      n = 0;
      got = 1'b0;
      while (n < 400 && !got) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 160) check("cmd_snt_mid", 32'(cmd_snt), 32'd0);
         if (cmd_snt === 1'b1) got = 1'b1;
      end
      check("cmd_snt_latency", 32'(n), 32'd321);
   endtask

   task automatic rx_timed(input logic [7:0] b, output int low_n);
      int n;
      bit done;
      rx_exp_q.push_back(b);
      @(negedge clk);
      n = 0;
      low_n = 0;
      done = 1'b0;
      fork
         robot_send(b);
         begin
            while (n < 300 && !done) begin
               @(posedge clk);
               n++;
               #1;
               if (resp_rdy !== 1'b1 && low_n == 0) low_n = n;
               else if (resp_rdy === 1'b1 && low_n != 0) done = 1'b1;
            end
         end
      join
      check("resp_rdy_latency", 32'(n), 32'd154);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int ln;
      tx_tab[0] = '{c: 16'h43F2, hi: 8'h43, lo: 8'hF2};
      tx_tab[1] = '{c: 16'h2000, hi: 8'h20, lo: 8'h00};
      tx_tab[2] = '{c: 16'h5BF3, hi: 8'h5B, lo: 8'hF3};
      tx_tab[3] = '{c: 16'hFF80, hi: 8'hFF, lo: 8'h80};
      rx_tab[0] = '{b: 8'h3C, exp_resp: 8'h3C};
      rx_tab[1] = '{b: 8'h00, exp_resp: 8'h00};
      rx_tab[2] = '{b: 8'hFF, exp_resp: 8'hFF};
      rx_tab[3] = '{b: 8'h81, exp_resp: 8'h81};

      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", 32'(tx_line), 32'd1);
      check("reset_cmd_snt", 32'(cmd_snt), 32'd0);
      check("reset_resp_rdy", 32'(resp_rdy), 32'd0);
      check("reset_resp", 32'(resp), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 4; i++) send_timed(tx_tab[i].c, tx_tab[i].hi, tx_tab[i].lo);

      // Request arriving mid-frame must not disturb the latched command.
      fork
         send_timed(16'h43F2, 8'h43, 8'hF2);
         begin
            repeat (60) @(negedge clk);
            cmd = 16'h5001;
            snd_cmd = 1'b1;
            @(negedge clk);
            snd_cmd = 1'b0;
         end
      join
      send_timed(16'h5001, 8'h50, 8'h01);

      rx_timed(8'hA5, ln);
      check("resp_after_ack", 32'(resp), 32'hA5);
      rx_timed(8'h5A, ln);
      check("resp_rdy_clear_at_start", 32'(ln), 32'd3);
      check("resp_after_5a", 32'(resp), 32'h5A);
      for (int i = 0; i < 4; i++) begin
         rx_timed(rx_tab[i].b, ln);
         check("resp_table", 32'(resp), 32'(rx_tab[i].exp_resp));
      end

      // Reset during the low byte.
      tx_exp_q.push_back(8'h40);
      tx_exp_q.push_back(8'h05);
      @(negedge clk);
      cmd = 16'h4005;
      snd_cmd = 1'b1;
      @(posedge clk);
      #1;
      snd_cmd = 1'b0;
      repeat (241) @(negedge clk);
      check("pre_reset_tx_low", 32'(tx_line), 32'd0);
      rst = 1'b1;
      tx_exp_q.delete();
      @(posedge clk);
      #1;
      check("midrst_tx", 32'(tx_line), 32'd1);
      check("midrst_cmd_snt", 32'(cmd_snt), 32'd0);
      check("midrst_resp_rdy", 32'(resp_rdy), 32'd0);
      check("midrst_resp", 32'(resp), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("post_rst_idle_cmd_snt", 32'(cmd_snt), 32'd0);
      check("post_rst_idle_tx", 32'(tx_line), 32'd1);
      send_timed(16'h2000, 8'h20, 8'h00);

      fork
         send_timed(16'h2000, 8'h20, 8'h00);
         rx_timed(8'hA5, ln);
      join
      check("sim_resp", 32'(resp), 32'hA5);

      repeat (40) @(negedge clk);
      check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
      check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
